// File: rtl/btn_pkg.sv
// Shared button codes and encoder state encoding for the press encoder and the
// game FSM's verify logic.
package btn_pkg;

   localparam logic [1:0] BTN_CODE_NONE = 2'd0;
   localparam logic [1:0] BTN_CODE_0    = 2'd1;
   localparam logic [1:0] BTN_CODE_1    = 2'd2;
   localparam logic [1:0] BTN_CODE_2    = 2'd3;

   typedef enum logic {
      ENC_IDLE = 1'b0,
      ENC_HELD = 1'b1
   } enc_state_e;

   // Code of the lowest pressed button; NONE when nothing is pressed.
   function automatic logic [1:0] btn_code(input logic [2:0] deb);
      logic [1:0] code;
      code = BTN_CODE_NONE;
      if (deb[0])      code = BTN_CODE_0;
      else if (deb[1]) code = BTN_CODE_1;
      else if (deb[2]) code = BTN_CODE_2;
      return code;
   endfunction

   function automatic logic btn_single(input logic [2:0] v);
      return (v != 3'd0) && ((v & (v - 3'd1)) == 3'd0);
   endfunction

endpackage

// File: rtl/btn_press_encoder_if.sv
// Valid/ready event channel from the press encoder to the game FSM.
interface btn_press_encoder_if;
   logic       press_valid;
   logic       press_ready;
   logic [1:0] press_code;

   modport master (output press_valid, output press_code, input press_ready);
   modport slave  (input press_valid, input press_code, output press_ready);
endinterface

// File: rtl/btn_debounce.sv
// One-bit two-flop synchroniser followed by a counting debouncer; the level
// is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 20
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_i,
   output logic deb_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) deb_d = sync2_q;
         else                   cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign deb_o = deb_q;

endmodule

// File: rtl/btn_press_encoder.sv
// Debounces three push-buttons and emits one coded event per clean single
// press on a one-deep valid/ready output register.
module btn_press_encoder
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 20,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [2:0]                 btn_raw,
   input  logic                       en,
   btn_press_encoder_if.master        press,
   output logic                       btn_held,
   output logic                       multi_err,
   output logic                       overflow
);

   logic [2:0] btn_act;
   logic [2:0] deb;

   assign btn_act = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

   for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_deb (
         .clock (clock),
         .reset (reset),
         .btn_i (btn_act[gi]),
         .deb_o (deb[gi])
      );
   end

   enc_state_e state_q, state_d;
   logic [2:0] deb_prev_q;
   logic       valid_q, valid_d;
   logic [1:0] code_q, code_d;
   logic       held_q, held_d;
   logic       multi_q, multi_d;
   logic       ovf_q, ovf_d;
   logic       ev;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= ENC_IDLE;
         deb_prev_q <= '0;
         valid_q    <= 1'b0;
         code_q     <= BTN_CODE_NONE;
         held_q     <= 1'b0;
         multi_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         deb_prev_q <= deb;
         valid_q    <= valid_d;
         code_q     <= code_d;
         held_q     <= held_d;
         multi_q    <= multi_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ev      = 1'b0;
      multi_d = 1'b0;
      held_d  = |deb;
      case (state_q)
         ENC_IDLE: begin
            if (deb != 3'd0) begin
               state_d = ENC_HELD;
               if (btn_single(deb)) ev = 1'b1;
               else                 multi_d = 1'b1;
            end
         end
         ENC_HELD: begin
            if (deb == 3'd0)                        state_d = ENC_IDLE;
            else if ((deb & ~deb_prev_q) != 3'd0)   multi_d = 1'b1;
         end
         default: state_d = ENC_IDLE;
      endcase
   end

   // Accept and load may share an edge: the slot frees before the new event lands.
   always_comb begin
      valid_d = valid_q;
      code_d  = code_q;
      ovf_d   = 1'b0;
      if (valid_q && press.press_ready) valid_d = 1'b0;
      if (ev && en) begin
         if (valid_q && !press.press_ready) begin
            ovf_d = 1'b1;
         end else begin
            valid_d = 1'b1;
            code_d  = btn_code(deb);
         end
      end
   end

   assign press.press_valid = valid_q;
   assign press.press_code  = code_q;
   assign btn_held          = held_q;
   assign multi_err         = multi_q;
   assign overflow          = ovf_q;

endmodule

// File: doc/btn_press_encoder.md
Name: btn_press_encoder

Overview:
- Player-side producer of button events for the Genius game FSM, which consumes them during its input phase.
- Synchronises and debounces the three raw push-buttons, detects clean single presses and encodes each as a 2-bit code.
- Delivers each code as one event on a valid/ready handshake, so the game FSM sees exactly one event per physical press.
- Sits between the board KEY pins and the game FSM, replacing direct level sampling of btn.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive synchronised cycles a button level must hold before it is accepted; board build uses 500000.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- BTN_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed (board KEYs); 0 = active-high.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-low; clock clock.
- btn_raw  in  3  asynchronous raw button pins.
- en  in  1  1 = events are accepted into the output register; 0 = detected presses are discarded.
- press_ready  in  1  consumer accepts the pending event.
- press_valid  out  1  event pending.
- press_code  out  2  pending code: btn[0]=1, btn[1]=2, btn[2]=3; 0 never issued.
- btn_held  out  1  any debounced button currently pressed.
- multi_err  out  1  one-cycle pulse: more than one button became pressed before release.
- overflow  out  1  one-cycle pulse: event dropped because press_valid was already high.

Behaviour:
- Reset (reset==0 at a clock edge) clears all of the following to 0: sync flops, debounce counters, debounced levels (released), FSM (IDLE), press_valid, press_code, btn_held, multi_err, overflow.
- Reset mid-press: after reset release, the still-held button must pass a full debounce and produce a new event.
- Polarity: apply BTN_ACTIVE_LOW inversion before synchronisation; all logic downstream of it is active-high.
- Synchroniser: two flops per bit.
- Debounce, per bit:
  - The counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments each cycle.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- btn_held = OR of debounced levels, registered.
- Encoder FSM on the debounced vector deb[2:0]:
  - IDLE: deb==0 -> stay. Exactly one bit set -> raise an event with the code of that bit, go HELD. Two or more bits set in the same cycle -> pulse multi_err, no event, go HELD.
  - HELD: deb==0 -> IDLE. Any additional bit rising while in HELD -> pulse multi_err once per rising bit; no event.
  - No event is ever raised from HELD; the next event requires a return to IDLE.
- Output register (one deep):
  - Raised event with en==1 and press_valid==0 -> press_valid<=1 and press_code<=code on the same edge the FSM leaves IDLE.
  - Raised event with en==0 -> discarded silently; no overflow.
  - Raised event with press_valid==1 -> new event dropped, pending event kept, overflow pulses.
  - press_valid && press_ready at an edge -> press_valid<=0. press_code holds its last value.
  - Accept and new event in the same cycle -> the pending event is consumed and the new event is loaded; press_valid stays 1; no overflow.
  - press_valid and press_code are stable while press_valid && !press_ready.
- Latency: raw edge sampled at edge k -> press_valid high after edge k+DEBOUNCE_CYCLES+2, i.e. visible DEBOUNCE_CYCLES+2 cycles after the sampling edge.
- Release timing has no output except btn_held falling, after the same latency.

Decomposition:
- Shared package btn_pkg:
  - Code constants BTN_CODE_NONE=2'd0, BTN_CODE_0=2'd1, BTN_CODE_1=2'd2, BTN_CODE_2=2'd3.
  - FSM state encoding ENC_IDLE, ENC_HELD.
  - Game FSM's verify logic uses the same code constants.
- Sub-module btn_debounce: one bit, synchroniser plus counter; parameters DEBOUNCE_CYCLES and CNT_W; instantiated 3 times.
- Encoder FSM and output register live in the top.

Test Plan (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=0 unless noted):
- Clean press: btn_raw=3'b010 held 20 cycles, en=1, press_ready=0 -> press_valid rises 6 cycles after the sampling edge with press_code=2 and stays high. Pulse press_ready 1 cycle -> press_valid=0 next edge. No second event during the hold.
- Glitch rejection: btn_raw[0] high for 3 cycles, then low -> no press_valid, btn_held stays 0. Same pulse for 4 cycles -> exactly one event, code=1.
- Simultaneous press: btn_raw 0 -> 3'b101 in one cycle -> multi_err pulses once, no press_valid. After release to 0 and a press of btn[2] -> event code=3.
- Overflow and back-to-back: press/release btn[0], then press btn[1] with press_ready=0 throughout -> pending code=1 kept, overflow pulses once. Repeat with press_ready=1 on the load cycle of the second event -> press_valid stays 1, code=2, no overflow.
- en gating: en=0 during a btn[2] press -> no event, btn_held=1. Set en=1 while still held -> still no event. Release and press again -> event code=3.
- Reset mid-press, BTN_ACTIVE_LOW=1: btn_raw=3'b110 held; drive reset=0 for 2 cycles after press_valid is high -> all outputs 0. Keep the button held -> new event code=1 arrives 6 cycles after reset returns to 1.
